// File: rtl/ps2_key_button.sv
// ps2_key_button
//   Receive-only PS/2 keyboard front end running on the pixel clock (clk_p).
//   Synchronises and filters the PS/2 clock/data pads, deframes 11-bit
//   device-to-host frames, tracks the E0/F0 prefixes and reports decoded scan
//   codes.  It also keeps level "held" flags for the jump and reset keys, which
//   downstream logic ORs with the other button sources.
//
// Ports
//   clk         in   system clock (25.2 MHz pixel clock)
//   resetn      in   asynchronous active-low reset
//   ps2_clk_i   in   raw PS/2 clock line (input only, never driven)
//   ps2_dat_i   in   raw PS/2 data line
//   code        out  last decoded scan code (held between strobes)
//   code_valid  out  one-cycle strobe: code/code_break/code_ext are valid
//   code_break  out  code was preceded by F0
//   code_ext    out  code was preceded by E0
//   frame_err   out  one-cycle strobe on framing, parity or timeout error
//   jump_key    out  jump key currently held
//   reset_key   out  reset key currently held

module ps2_key_button #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 5040,
  parameter logic [7:0]  JUMP_CODE   = 8'h29,
  parameter logic [7:0]  RESET_CODE  = 8'h76
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       code_break,
  output logic       code_ext,
  output logic       frame_err,
  output logic       jump_key,
  output logic       reset_key
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam logic [7:0] BRK_PREFIX = 8'hF0;
  localparam logic [7:0] BAT_CODE   = 8'hAA;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_DECODE
  } state_t;

  // ---------------------------------------------------------------------------
  // 2-FF synchronisers; idle-high reset value so release does not fake an edge
  // ---------------------------------------------------------------------------
  logic clk_m, clk_s;
  logic dat_m, dat_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_m <= 1'b1;
      clk_s <= 1'b1;
      dat_m <= 1'b1;
      dat_s <= 1'b1;
    end else begin
      clk_m <= ps2_clk_i;
      clk_s <= clk_m;
      dat_m <= ps2_dat_i;
      dat_s <= dat_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Clock filter: the filtered clock follows the synchronised clock only after
  // FILTER_LEN consecutive differing samples.  The falling transition of the
  // filtered clock is registered as bit_evt together with the data sampled on
  // that same cycle.
  // ---------------------------------------------------------------------------
  logic          clk_f;
  logic [FW-1:0] flt_cnt;
  logic          bit_evt;
  logic          bit_dat;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_f   <= 1'b1;
      flt_cnt <= '0;
      bit_evt <= 1'b0;
      bit_dat <= 1'b1;
    end else begin
      bit_evt <= 1'b0;
      if (clk_s == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f   <= clk_s;
        flt_cnt <= '0;
        if (!clk_s) begin
          bit_evt <= 1'b1;
          bit_dat <= dat_s;
        end
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive / decode FSM and key tracking
  // ---------------------------------------------------------------------------
  state_t        state;
  logic [3:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          stop_bit;
  logic [TW-1:0] to_cnt;
  logic          ext_f;
  logic          brk_f;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      stop_bit   <= 1'b0;
      to_cnt     <= '0;
      ext_f      <= 1'b0;
      brk_f      <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
      code_break <= 1'b0;
      code_ext   <= 1'b0;
      frame_err  <= 1'b0;
      jump_key   <= 1'b0;
      reset_key  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;

      // Held flags follow the registered strobe, i.e. update in the cycle
      // where code_valid is high.
      if (code_valid) begin
        if (code == BAT_CODE) begin
          jump_key  <= 1'b0;
          reset_key <= 1'b0;
        end else if (!code_ext) begin
          if (code == JUMP_CODE)  jump_key  <= ~code_break;
          if (code == RESET_CODE) reset_key <= ~code_break;
        end
      end

      case (state)
        S_IDLE: begin
          to_cnt <= '0;
          bitcnt <= '0;
          // A stray falling edge with data high is not a start bit; ignore it.
          if (bit_evt && !bit_dat) begin
            state  <= S_RECV;
            bitcnt <= 4'd1;
          end
        end

        S_RECV: begin
          // Terminal count takes priority over a coincident bit event.
          if (to_cnt == TW'(TIMEOUT_CYC)) begin
            frame_err <= 1'b1;
            bitcnt    <= '0;
            to_cnt    <= '0;
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
            state     <= S_IDLE;
          end else if (bit_evt) begin
            to_cnt <= '0;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt <= 4'd8) begin
              shreg <= {bit_dat, shreg[7:1]};
            end else if (bitcnt == 4'd9) begin
              par_bit <= bit_dat;
            end else begin
              stop_bit <= bit_dat;
              state    <= S_CHECK;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_CHECK: begin
          bitcnt <= '0;
          to_cnt <= '0;
          // Decode results are registered on the way into S_DECODE so that
          // the strobe and its payload are visible during the S_DECODE cycle.
          if (stop_bit && (^{shreg, par_bit})) begin
            state <= S_DECODE;
            if (shreg == EXT_PREFIX) begin
              ext_f <= 1'b1;
            end else if (shreg == BRK_PREFIX) begin
              brk_f <= 1'b1;
            end else begin
              code       <= shreg;
              code_ext   <= ext_f;
              code_break <= brk_f;
              code_valid <= 1'b1;
              ext_f      <= 1'b0;
              brk_f      <= 1'b0;
            end
          end else begin
            frame_err <= 1'b1;
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
            state     <= S_IDLE;
          end
        end

        S_DECODE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_button.sv
module tb_ps2_key_button;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_dat_i = 1'b1;
  logic [7:0] code;
  logic       code_valid, code_break, code_ext, frame_err, jump_key, reset_key;

  ps2_key_button #(
    .FILTER_LEN (4),
    .TIMEOUT_CYC(5040),
    .JUMP_CODE  (8'h29),
    .RESET_CODE (8'h76)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .code      (code),
    .code_valid(code_valid),
    .code_break(code_break),
    .code_ext  (code_ext),
    .frame_err (frame_err),
    .jump_key  (jump_key),
    .reset_key (reset_key)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         brk;
    bit         ext;
    int         lo;
    int         hi;
  } exp_t;

  exp_t q[$];

  localparam int NO_LIMIT = 32'h7fffffff;

  // Monitor: every strobe from the DUT consumes one expected entry.
  always @(negedge clk) begin
    if (resetn && (code_valid || frame_err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: cyc=%0d valid=%b err=%b code=%h brk=%b ext=%b, required no output",
                 cyc, code_valid, frame_err, code, code_break, code_ext);
      end else begin
        exp_t e;
        bit   bad;
        e = q.pop_front();
        if (e.is_err)
          bad = !frame_err || code_valid;
        else
          bad = !code_valid || frame_err || (code !== e.code) ||
                (code_break !== e.brk) || (code_ext !== e.ext);
        if (cyc < e.lo || cyc > e.hi) bad = 1'b1;
        if (bad) begin
          errors++;
          $display("FAIL strobe: cyc=%0d valid=%b err=%b code=%h brk=%b ext=%b, required err=%b code=%h brk=%b ext=%b cyc %0d..%0d",
                   cyc, code_valid, frame_err, code, code_break, code_ext,
                   e.is_err, e.code, e.brk, e.ext, e.lo, e.hi);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push_code(input logic [7:0] b, input bit brk, input bit ext,
                           input int lo, input int hi);
    exp_t e;
    e.is_err = 1'b0; e.code = b; e.brk = brk; e.ext = ext; e.lo = lo; e.hi = hi;
    q.push_back(e);
  endtask

  task automatic push_err(input int lo, input int hi);
    exp_t e;
    e.is_err = 1'b1; e.code = 8'h00; e.brk = 1'b0; e.ext = 1'b0; e.lo = lo; e.hi = hi;
    q.push_back(e);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit pflip, input bit stopv);
    logic par;
    par = (~^b) ^ pflip;
    return {stopv, par, b, 1'b0};
  endfunction

  // Bit i falls 20 cycles into its 40-cycle slot: fall cycle = start + 20 + 40*i.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat_i = bits[i];
      tick(20);
      ps2_clk_i = 1'b0;
      tick(20);
      ps2_clk_i = 1'b1;
    end
    ps2_dat_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pflip, input bit stopv);
    send_bits(mk_frame(b, pflip, stopv), 11);
    tick(20);
  endtask

  task automatic send_code(input logic [7:0] b, input bit brk, input bit ext);
    push_code(b, brk, ext, 0, NO_LIMIT);
    send_frame(b, 1'b0, 1'b1);
  endtask

  initial begin
    #(60000 * 40);
    $display("FAIL watchdog: simulation did not finish within 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;

    #5 resetn = 1'b0;
    tick(3);
    chk("reset_code", code, 8'h00);
    chk("reset_strobes", {5'b0, code_valid, frame_err, code_break}, 8'h00);
    chk("reset_flags", {5'b0, code_ext, jump_key, reset_key}, 8'h00);
    resetn = 1'b1;
    tick(10);

    // Clean 0x1C; strobe exactly 8 cycles after the raw stop-bit fall
    // (2 sync + 4 filter -> bit event at +6, CHECK at +7, strobe at +8).
    c0 = cyc;
    push_code(8'h1C, 1'b0, 1'b0, c0 + 420 + 8, c0 + 420 + 8);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("clean_code_held", code, 8'h1C);

    // Jump key make / typematic / break
    send_code(8'h29, 1'b0, 1'b0);
    chk("jump_make", {7'b0, jump_key}, 8'h01);
    send_code(8'h29, 1'b0, 1'b0);
    chk("jump_typematic", {7'b0, jump_key}, 8'h01);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_code(8'h29, 1'b1, 1'b0);
    chk("jump_break", {7'b0, jump_key}, 8'h00);
    send_code(8'h29, 1'b0, 1'b0);
    chk("jump_make2", {7'b0, jump_key}, 8'h01);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_code(8'h29, 1'b0, 1'b1);
    chk("jump_ext_make", {7'b0, jump_key}, 8'h01);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_code(8'h29, 1'b1, 1'b1);
    chk("jump_ext_break", {7'b0, jump_key}, 8'h01);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_code(8'h29, 1'b1, 1'b0);
    chk("jump_break2", {7'b0, jump_key}, 8'h00);

    // Bad frames
    push_err(0, NO_LIMIT);
    send_frame(8'h76, 1'b1, 1'b1);
    chk("bad_parity_reset_key", {7'b0, reset_key}, 8'h00);
    push_err(0, NO_LIMIT);
    send_frame(8'h76, 1'b0, 1'b0);
    chk("bad_stop_reset_key", {7'b0, reset_key}, 8'h00);
    chk("bad_frames_code_held", code, 8'h29);

    // Short clock glitches with data low must not start a frame
    ps2_dat_i = 1'b0;
    for (int g = 0; g < 5; g++) begin
      ps2_clk_i = 1'b0;
      tick(2);
      ps2_clk_i = 1'b1;
      tick(10);
    end
    ps2_dat_i = 1'b1;
    tick(50);

    // Timeout: hold jump first, then 4 bits and a long idle line
    send_code(8'h29, 1'b0, 1'b0);
    c0 = cyc;
    push_err(c0 + 140 + 5040, c0 + 140 + 5055);
    send_bits(mk_frame(8'h55, 1'b0, 1'b1), 4);
    tick(6000);
    chk("timeout_keeps_jump", {7'b0, jump_key}, 8'h01);
    send_code(8'h76, 1'b0, 1'b0);
    chk("after_timeout_reset_key", {7'b0, reset_key}, 8'h01);

    // Reset mid-frame
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 4);
    tick(5);
    resetn = 1'b0;
    tick(2);
    chk("midreset_code", code, 8'h00);
    chk("midreset_flags", {6'b0, jump_key, reset_key}, 8'h00);
    resetn = 1'b1;
    tick(100);
    send_code(8'h29, 1'b0, 1'b0);
    chk("post_reset_jump", {7'b0, jump_key}, 8'h01);

    // BAT clears both held flags
    send_code(8'h76, 1'b0, 1'b0);
    chk("both_held", {6'b0, jump_key, reset_key}, 8'h03);
    send_code(8'hAA, 1'b0, 1'b0);
    chk("bat_clears", {6'b0, jump_key, reset_key}, 8'h00);

    tick(100);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expected: got %0d outstanding strobes, required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
